// File: rtl/rv_mc_pkg.sv
// Shared definitions for the multi-cycle RISC-V control path: FSM states,
// opcodes and the datapath select encodings used by the main FSM and ALU decoder.
package rv_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_ITYPE = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;

endpackage

// File: rtl/main_fsm_imm_src_decoder.sv
// Immediate-format select derived from the opcode alone; unknown opcodes
// fall back to the I-type format.
module imm_src_decoder
    import rv_mc_pkg::*;
(
    input  logic [6:0] op,
    output logic [2:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE: imm_src = IMM_S;
            OP_BEQ:   imm_src = IMM_B;
            OP_JAL:   imm_src = IMM_J;
            default:  imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/main_fsm.sv
// Main control FSM of the multi-cycle RISC-V core: sequences fetch/decode/
// execute/memory/writeback, handles the memory ready handshake and counts retires.
module main_fsm
    import rv_mc_pkg::*;
#(
    parameter int unsigned COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               adr_src,
    output logic               ir_write,
    output logic               pc_update,
    output logic               branch,
    output logic               pc_write,
    output logic               reg_write,
    output logic               mem_write,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_op,
    output logic [2:0]         imm_src,
    output logic               illegal,
    output logic [3:0]         state,
    output logic [COUNT_W-1:0] instret
);

    state_t             state_q;
    state_t             state_d;
    logic               illegal_q;
    logic [COUNT_W-1:0] instret_q;
    logic               retire;

    logic mem_req_raw;
    logic ir_write_raw;
    logic pc_update_raw;
    logic branch_raw;
    logic reg_write_raw;
    logic mem_write_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BEQ:            state_d = S_BEQ;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req_raw   = 1'b0;
        adr_src       = 1'b0;
        ir_write_raw  = 1'b0;
        pc_update_raw = 1'b0;
        branch_raw    = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RD2;
        result_src    = RES_ALUOUT;
        alu_op        = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req_raw   = 1'b1;
                alu_src_b     = SRCB_FOUR;
                result_src    = RES_ALURESULT;
                ir_write_raw  = mem_ready;
                pc_update_raw = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_req_raw = 1'b1;
                adr_src     = 1'b1;
            end
            S_MEMWB: begin
                result_src    = RES_DATA;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_raw   = 1'b1;
                adr_src       = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALU_RTYPE;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_ITYPE;
            end
            S_JAL: begin
                alu_src_a     = SRCA_OLDPC;
                alu_src_b     = SRCB_FOUR;
                pc_update_raw = 1'b1;
            end
            S_BEQ: begin
                alu_src_a  = SRCA_RD1;
                alu_op     = ALU_SUB;
                branch_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset masks every enable combinationally so a reset mid-instruction
    // never lets a partial write through during the reset cycle itself.
    assign mem_req   = mem_req_raw   & ~reset;
    assign ir_write  = ir_write_raw  & ~reset;
    assign pc_update = pc_update_raw & ~reset;
    assign branch    = branch_raw    & ~reset;
    assign reg_write = reg_write_raw & ~reset;
    assign mem_write = mem_write_raw & ~reset;
    assign pc_write  = pc_update | (branch & zero);

    assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BEQ)
                 || ((state_q == S_MEMWRITE) && mem_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (state_d == S_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    imm_src_decoder u_imm_src_decoder (
        .op      (op),
        .imm_src (imm_src)
    );

    assign illegal = illegal_q;
    assign state   = state_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: the driver walks instructions through a
// spec-level model and queues per-cycle expectations; a monitor checks them.
module tb_main_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    op;
    logic          zero;
    logic          mem_ready;
    logic          mem_req, adr_src, ir_write, pc_update, branch, pc_write;
    logic          reg_write, mem_write, illegal;
    logic [1:0]    alu_src_a, alu_src_b, result_src, alu_op;
    logic [2:0]    imm_src;
    logic [3:0]    state;
    logic [CW-1:0] instret;

    main_fsm #(.COUNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_update  (pc_update),
        .branch     (branch),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_op     (alu_op),
        .imm_src    (imm_src),
        .illegal    (illegal),
        .state      (state),
        .instret    (instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0]   ctrl;
        logic [CW-1:0] cnt;
        int            idx;
    } exp_t;

    exp_t     sb[$];
    int       vectors = 0;
    int       miscompares = 0;
    int       cyc_idx = 0;
    int       instret_m = 0;
    bit       ill_m = 1'b0;
    bit       done = 1'b0;

    localparam int FE = 0, DE = 1, MA = 2, MR = 3, MWB = 4, MW = 5,
                   XR = 6, AWB = 7, XI = 8, JL = 9, BQ = 10, TR = 11;

    // Control vector required by the state table for one cycle.
    function automatic logic [23:0] expect_vec(int st, bit mr, bit z, logic [6:0] o,
                                               bit rst, bit ill);
        logic mreq, adr, irw, pcu, br, pcw, rw, mw;
        logic [1:0] a, b, res, aop;
        logic [2:0] imm;
        {mreq, adr, irw, pcu, br, rw, mw} = '0;
        {a, b, res, aop} = '0;
        case (st)
            FE:  begin mreq = 1; b = 2'b10; res = 2'b10; irw = mr; pcu = mr; end
            DE:  begin a = 2'b01; b = 2'b01; end
            MA:  begin a = 2'b10; b = 2'b01; end
            MR:  begin mreq = 1; adr = 1; end
            MWB: begin res = 2'b01; rw = 1; end
            MW:  begin mreq = 1; adr = 1; mw = 1; end
            XR:  begin a = 2'b10; aop = 2'b10; end
            AWB: begin rw = 1; end
            XI:  begin a = 2'b10; b = 2'b01; aop = 2'b11; end
            JL:  begin a = 2'b01; b = 2'b10; pcu = 1; end
            BQ:  begin a = 2'b10; aop = 2'b01; br = 1; end
            default: ;
        endcase
        case (o)
            7'b0100011: imm = 3'b001;
            7'b1100011: imm = 3'b010;
            7'b1101111: imm = 3'b011;
            default:    imm = 3'b000;
        endcase
        if (rst) {mreq, irw, pcu, br, rw, mw} = '0;
        pcw = pcu | (br & z);
        return {mreq, adr, irw, pcu, br, pcw, rw, mw, a, b, res, aop, imm, ill, 4'(st)};
    endfunction

    // One clock cycle: drive inputs, queue expectation, advance model, wait for edge.
    task automatic cyc(input int st, input bit mr, input bit z, input bit rst);
        exp_t e;
        bit   ill;
        reset     = rst;
        mem_ready = mr;
        zero      = z;
        ill       = ill_m | (st == TR);
        e.ctrl    = expect_vec(st, mr, z, op, rst, ill);
        e.cnt     = CW'(instret_m);
        e.idx     = cyc_idx;
        sb.push_back(e);
        cyc_idx++;
        if (rst) begin
            instret_m = 0;
            ill_m     = 1'b0;
        end else begin
            if (st == MWB || st == AWB || st == BQ || (st == MW && mr))
                instret_m = (instret_m + 1) % (1 << CW);
            if (st == TR) ill_m = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic bit rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Run one full instruction; kind: 0 lw, 1 sw, 2 R, 3 I, 4 beq, 5 jal.
    task automatic run_instr(input int kind, input int wf, input int wm, input bit z);
        case (kind)
            0: op = 7'b0000011;
            1: op = 7'b0100011;
            2: op = 7'b0110011;
            3: op = 7'b0010011;
            4: op = 7'b1100011;
            default: op = 7'b1101111;
        endcase
        for (int i = 0; i <= wf; i++) cyc(FE, i == wf, rnd(), 1'b0);
        cyc(DE, rnd(), rnd(), 1'b0);
        case (kind)
            0: begin
                cyc(MA, rnd(), rnd(), 1'b0);
                for (int i = 0; i <= wm; i++) cyc(MR, i == wm, rnd(), 1'b0);
                cyc(MWB, rnd(), rnd(), 1'b0);
            end
            1: begin
                cyc(MA, rnd(), rnd(), 1'b0);
                for (int i = 0; i <= wm; i++) cyc(MW, i == wm, rnd(), 1'b0);
            end
            2: begin cyc(XR, rnd(), rnd(), 1'b0); cyc(AWB, rnd(), rnd(), 1'b0); end
            3: begin cyc(XI, rnd(), rnd(), 1'b0); cyc(AWB, rnd(), rnd(), 1'b0); end
            4: cyc(BQ, rnd(), z, 1'b0);
            default: begin cyc(JL, rnd(), rnd(), 1'b0); cyc(AWB, rnd(), rnd(), 1'b0); end
        endcase
    endtask

    initial begin
        logic [23:0] act;
        exp_t        e;
        while (!done) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {mem_req, adr_src, ir_write, pc_update, branch, pc_write, reg_write,
                       mem_write, alu_src_a, alu_src_b, result_src, alu_op, imm_src,
                       illegal, state};
                vectors++;
                if (act !== e.ctrl) begin
                    miscompares++;
                    $display("FAIL ctrl cycle %0d: got %h expected %h", e.idx, act, e.ctrl);
                end
                vectors++;
                if (instret !== e.cnt) begin
                    miscompares++;
                    $display("FAIL instret cycle %0d: got %0d expected %0d",
                             e.idx, instret, e.cnt);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; op = 7'b0110011; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc(FE, 1'b0, 1'b0, 1'b1);

        run_instr(2, 0, 0, 1'b0);          // R-type
        run_instr(0, 0, 2, 1'b0);          // lw, two MEMREAD waits
        run_instr(1, 0, 1, 1'b0);          // sw, one MEMWRITE wait
        run_instr(4, 0, 0, 1'b1);          // beq taken
        run_instr(4, 0, 0, 1'b0);          // beq not taken
        run_instr(5, 1, 0, 1'b0);          // jal, one fetch wait
        run_instr(3, 0, 0, 1'b0);          // I-type

        // Reset aborts a load in MEMREAD: no writeback, count cleared.
        op = 7'b0000011;
        cyc(FE, 1'b1, 1'b0, 1'b0);
        cyc(DE, 1'b1, 1'b0, 1'b0);
        cyc(MA, 1'b1, 1'b0, 1'b0);
        cyc(MR, 1'b0, 1'b0, 1'b0);
        cyc(MR, 1'b1, 1'b0, 1'b1);
        run_instr(2, 0, 0, 1'b0);

        // Illegal opcode parks in TRAP until reset.
        op = 7'b1111111;
        cyc(FE, 1'b1, 1'b0, 1'b0);
        cyc(DE, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) cyc(TR, rnd(), rnd(), 1'b0);
        cyc(TR, 1'b1, 1'b1, 1'b1);
        run_instr(4, 0, 0, 1'b1);

        // Random traffic; the 4-bit counter wraps several times.
        for (int n = 0; n < 80; n++)
            run_instr($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 2), rnd());

        repeat (2) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/main_fsm.md
# main_fsm

Main control state machine for the multi-cycle RISC-V processor. Sequences each instruction through fetch, decode, execute, memory and writeback cycles. Drives datapath mux selects and write enables, plus the 2-bit `alu_op` consumed by the ALU decoder. Also handles a memory ready handshake, flags illegal opcodes, and counts retired instructions.

## Interface
Parameters:
- `COUNT_W`, 32, width of the retired-instruction counter

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high
- `op`  in  7  opcode field `instr[6:0]` from the instruction register
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access in progress
- `adr_src`  out  1  memory address select: 0 = PC, 1 = Result
- `ir_write`  out  1  load instruction register and OldPC
- `pc_update`  out  1  unconditional PC write
- `branch`  out  1  conditional PC write
- `pc_write`  out  1  `pc_update | (branch & zero)`
- `reg_write`  out  1  register file write enable
- `mem_write`  out  1  data memory write enable
- `alu_src_a`  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1 register
- `alu_src_b`  out  2  ALU B select: 00 = RD2 register, 01 = ImmExt, 10 = constant 4
- `result_src`  out  2  Result select: 00 = ALUOut, 01 = Data register, 10 = ALUResult
- `alu_op`  out  2  00 = ADD, 01 = SUB (beq), 10 = R-type, 11 = I-type
- `imm_src`  out  3  000 = I, 001 = S, 010 = B, 011 = J
- `illegal`  out  1  sticky; set once the TRAP state is entered
- `state`  out  4  current state encoding, for debug
- `instret`  out  `COUNT_W`  number of retired instructions

## Operation
- Moore outputs decoded from `state`. Exceptions: `ir_write`, `pc_update`, `pc_write` and the state advance depend on `mem_ready` where noted below.
- Any output not listed for a state is 0.
- `imm_src` is combinational from `op` and independent of state. Unknown opcodes give 000.
- States, with encodings, outputs and next state:
  - FETCH (0): `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, `alu_op`=00, `result_src`=10. `ir_write` and `pc_update` are 1 only when `mem_ready`=1. Next: DECODE if `mem_ready`=1, else stay in FETCH.
  - DECODE (1): `alu_src_a`=01, `alu_src_b`=01, `alu_op`=00 (computes the branch target). Next state by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other opcode → TRAP
  - MEMADR (2): `alu_src_a`=10, `alu_src_b`=01, `alu_op`=00. Next: MEMREAD for a load, MEMWRITE for a store. `op` is sampled again in this state; the IR is stable.
  - MEMREAD (3): `mem_req`=1, `adr_src`=1, `result_src`=00. Stay until `mem_ready`=1, then go to MEMWB.
  - MEMWB (4): `result_src`=01, `reg_write`=1. Next: FETCH.
  - MEMWRITE (5): `mem_req`=1, `adr_src`=1, `result_src`=00, `mem_write`=1, held for every wait cycle. Stay until `mem_ready`=1, then go to FETCH.
  - EXECUTER (6): `alu_src_a`=10, `alu_src_b`=00, `alu_op`=10. Next: ALUWB.
  - ALUWB (7): `result_src`=00, `reg_write`=1. Next: FETCH.
  - EXECUTEI (8): `alu_src_a`=10, `alu_src_b`=01, `alu_op`=11. Next: ALUWB.
  - JAL (9): `alu_src_a`=01, `alu_src_b`=10, `alu_op`=00, `result_src`=00, `pc_update`=1. Next: ALUWB.
  - BEQ (10): `alu_src_a`=10, `alu_src_b`=00, `alu_op`=01, `result_src`=00, `branch`=1. Next: FETCH.
  - TRAP (11): all enables 0, `illegal`=1. Stays in TRAP until `reset`.
- Encodings 12–15 are unreachable and recover to FETCH on the next clock.
- `instret` increments by 1 on the clock edge of each terminal cycle:
  - MEMWB
  - ALUWB
  - BEQ
  - MEMWRITE, only in the cycle with `mem_ready`=1
- `instret` wraps modulo 2^`COUNT_W` and does not count in TRAP.

## Timing
- Reset: while `reset`=1, all write enables are forced to 0: `ir_write`, `pc_update`, `branch`, `pc_write`, `reg_write`, `mem_write`, `mem_req`.
- On the first edge with `reset`=1: `state` ← FETCH, `instret` ← 0, `illegal` ← 0.
- Reset mid-instruction aborts it. No partial writeback occurs and `instret` is not incremented.
- CPI with `mem_ready` tied high:
  - beq: 3
  - R-type, I-type, jal: 4
  - sw: 4
  - lw: 5
- Each wait cycle on FETCH, MEMREAD or MEMWRITE adds 1 cycle.
- Zero-latency handshake: `mem_ready` is sampled in the same cycle as `mem_req`. The access completes in any cycle where both are 1.
- `pc_write` is purely combinational; `zero` is used in the BEQ cycle only.

## Structure
- Shared package `rv_mc_pkg` holds:
  - state enum (4-bit, encodings above)
  - opcode constants
  - `alu_op` encodings (shared with the ALU decoder)
  - `alu_src_a`, `alu_src_b`, `result_src` and `imm_src` encodings
- One sub-module, `imm_src_decoder`: combinational mapping from `op` to `imm_src`.
- State register, `illegal` flag and `instret` counter live in `main_fsm`.

## Test plan
- **Reset:** assert `reset` mid-MEMREAD for one cycle → next `state`=0, `instret`=0, `reg_write` never asserted, `mem_req`=1.
- **R-type:** `op`=0110011, `mem_ready`=1 → states 0,1,6,7,0; `alu_op`=10 in state 6; `reg_write`=1 for one cycle; `instret` +1.
- **lw with memory waits:** `op`=0000011, `mem_ready` low for 2 cycles in MEMREAD → states 0,1,2,3,3,3,4,0 (7 cycles); `result_src`=01 and `reg_write`=1 in state 4.
- **sw with memory wait:** `op`=0100011, 1 wait cycle → `mem_write`=1 for 2 consecutive cycles; `instret` +1 only on the `mem_ready` cycle.
- **beq taken vs. not taken:** `zero`=1 → `pc_write`=1 in BEQ. `zero`=0 → `pc_write`=0, `alu_op`=01, `imm_src`=010. Both take 3 cycles.
- **Illegal opcode:** `op`=1111111 → states 0,1,11; `illegal`=1 and all enables 0 for 100 cycles; `reset` returns `state` to 0 and clears `illegal`.
